// File: rtl/user_lock_arbiter.sv
// user_lock_arbiter: round-robin arbiter guarding one 8-bit owner-locked register.
// Ports: clk, rst_n, req[3:0], gnt[3:0], wr_valid, wr_op[1:0], wr_data[7:0],
//   ack, nack, timeout, data_out[7:0], owner_id[1:0], final_lock, viol_cnt[7:0].
// Optional: define USR_LOCK_AUDIT_EN to build the saturating violation counter.
module user_lock_arbiter #(
    parameter int RESET_OWNER = 2,
    parameter int GNT_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    input  logic       wr_valid,
    input  logic [1:0] wr_op,
    input  logic [7:0] wr_data,
    output logic       ack,
    output logic       nack,
    output logic       timeout,
    output logic [7:0] data_out,
    output logic [1:0] owner_id,
    output logic       final_lock,
    output logic [7:0] viol_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    localparam logic [7:0] TMAX    = 8'(GNT_TIMEOUT - 1);
    localparam logic [1:0] RST_OWN = 2'(RESET_OWNER);

    logic [1:0] state;
    logic [1:0] ptr;
    logic [1:0] gidx;
    logic [7:0] timer;
    logic [1:0] sel;
    logic [1:0] idx;
    logic       found;
    logic       own_ok;
    logic       accept;

    // First requester at or after the pointer; scanning downward lets
    // the smallest rotation distance win.
    always_comb begin
        sel   = ptr;
        found = 1'b0;
        idx   = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    // Identity is the grant index, never anything the requester supplies.
    always_comb begin
        own_ok = (gidx == owner_id);
        accept = 1'b0;
        case (wr_op)
            2'b00:   accept = own_ok && !final_lock;
            2'b01:   accept = own_ok && !final_lock;
            2'b10:   accept = own_ok;
            default: accept = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            ptr        <= 2'd0;
            gidx       <= 2'd0;
            timer      <= 8'd0;
            gnt        <= 4'd0;
            ack        <= 1'b0;
            nack       <= 1'b0;
            timeout    <= 1'b0;
            data_out   <= 8'd0;
            owner_id   <= RST_OWN;
            final_lock <= 1'b0;
        end else begin
            ack     <= 1'b0;
            nack    <= 1'b0;
            timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        gnt   <= 4'b0001 << sel;
                        gidx  <= sel;
                        ptr   <= sel + 2'd1;
                        timer <= 8'd0;
                        state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (wr_valid) begin
                        gnt   <= 4'd0;
                        state <= S_RESP;
                        ack   <= accept;
                        nack  <= !accept;
                        if (accept) begin
                            case (wr_op)
                                2'b00:   data_out   <= wr_data;
                                2'b01:   owner_id   <= wr_data[1:0];
                                2'b10:   final_lock <= 1'b1;
                                default: ;
                            endcase
                        end
                    end else if (!req[gidx]) begin
                        gnt   <= 4'd0;
                        state <= S_IDLE;
                    end else if (timer == TMAX) begin
                        gnt     <= 4'd0;
                        timeout <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef USR_LOCK_AUDIT_EN
    logic viol_evt;
    logic [7:0] viol_q;

    // Counts the same events that raise nack or timeout on the next edge.
    always_comb begin
        viol_evt = 1'b0;
        if (state == S_GRANT) begin
            if (wr_valid)
                viol_evt = !accept;
            else if (req[gidx] && timer == TMAX)
                viol_evt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            viol_q <= 8'd0;
        else if (viol_evt && viol_q != 8'hFF)
            viol_q <= viol_q + 8'd1;
    end

    assign viol_cnt = viol_q;
`else
    assign viol_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_user_lock_arbiter.sv
// tb_user_lock_arbiter: vector table plus scoreboard bench for user_lock_arbiter.
// Ports: none (top-level bench).
module tb_user_lock_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       wr_valid;
    logic [1:0] wr_op;
    logic [7:0] wr_data;
    logic       ack;
    logic       nack;
    logic       timeout;
    logic [7:0] data_out;
    logic [1:0] owner_id;
    logic       final_lock;
    logic [7:0] viol_cnt;

    user_lock_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .gnt        (gnt),
        .wr_valid   (wr_valid),
        .wr_op      (wr_op),
        .wr_data    (wr_data),
        .ack        (ack),
        .nack       (nack),
        .timeout    (timeout),
        .data_out   (data_out),
        .owner_id   (owner_id),
        .final_lock (final_lock),
        .viol_cnt   (viol_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] user;
        logic [1:0] op;
        logic [7:0] data;
        logic       exp_ack;
        logic [7:0] exp_data;
        logic [1:0] exp_owner;
        logic       exp_final;
    } vec_t;

    typedef struct {
        logic a;
        logic n;
    } resp_t;

    int    total;
    int    bad;
    int    exp_viol;
    resp_t sb[$];
    vec_t  vecs[11];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic bump_viol();
`ifdef USR_LOCK_AUDIT_EN
        if (exp_viol < 255) exp_viol++;
`endif
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        req      = 4'd0;
        wr_valid = 1'b0;
        wr_op    = 2'd0;
        wr_data  = 8'd0;
        exp_viol = 0;
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (gnt != 4'd0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_txn(input vec_t v, input bit hold);
        bit    ok;
        resp_t r;
        wait_gnt(ok);
        chk("gnt_seen", 32'(ok), 32'd1);
        if (!ok) return;
        chk("gnt_onehot", 32'(gnt), 32'(4'b0001 << v.user));
        wr_valid = 1'b1;
        wr_op    = v.op;
        wr_data  = v.data;
        sb.push_back('{a: v.exp_ack, n: !v.exp_ack});
        if (!v.exp_ack) bump_viol();
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        if (!hold) req = 4'd0;
        r = sb.pop_front();
        chk("ack", 32'(ack), 32'(r.a));
        chk("nack", 32'(nack), 32'(r.n));
        chk("resp_gnt", 32'(gnt), 32'd0);
        chk("data_out", 32'(data_out), 32'(v.exp_data));
        chk("owner_id", 32'(owner_id), 32'(v.exp_owner));
        chk("final_lock", 32'(final_lock), 32'(v.exp_final));
        chk("viol_cnt", 32'(viol_cnt), 32'(exp_viol));
        @(posedge clk);
        #1;
        chk("pulse_len", 32'(ack | nack | timeout), 32'd0);
    endtask

    initial begin
        bit   ok;
        vec_t v;
        total = 0;
        bad   = 0;

        vecs[0]  = '{2'd2, 2'b00, 8'hA5, 1'b1, 8'hA5, 2'd2, 1'b0};
        vecs[1]  = '{2'd1, 2'b00, 8'h3C, 1'b0, 8'hA5, 2'd2, 1'b0};
        vecs[2]  = '{2'd2, 2'b01, 8'h01, 1'b1, 8'hA5, 2'd1, 1'b0};
        vecs[3]  = '{2'd1, 2'b00, 8'h77, 1'b1, 8'h77, 2'd1, 1'b0};
        vecs[4]  = '{2'd2, 2'b00, 8'h55, 1'b0, 8'h77, 2'd1, 1'b0};
        vecs[5]  = '{2'd1, 2'b01, 8'hFD, 1'b1, 8'h77, 2'd1, 1'b0};
        vecs[6]  = '{2'd1, 2'b11, 8'h00, 1'b0, 8'h77, 2'd1, 1'b0};
        vecs[7]  = '{2'd0, 2'b10, 8'h00, 1'b0, 8'h77, 2'd1, 1'b0};
        vecs[8]  = '{2'd1, 2'b10, 8'h00, 1'b1, 8'h77, 2'd1, 1'b1};
        vecs[9]  = '{2'd1, 2'b00, 8'hFF, 1'b0, 8'h77, 2'd1, 1'b1};
        vecs[10] = '{2'd1, 2'b10, 8'h00, 1'b1, 8'h77, 2'd1, 1'b1};

        do_reset();
        repeat (5) @(posedge clk);
        #1;
        chk("rst_data", 32'(data_out), 32'h00);
        chk("rst_owner", 32'(owner_id), 32'd2);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_final", 32'(final_lock), 32'd0);
        chk("rst_viol", 32'(viol_cnt), 32'd0);

        // wr_valid while idle must do nothing
        wr_valid = 1'b1;
        wr_data  = 8'h99;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        chk("idle_wr", 32'({ack, nack, data_out}), 32'h000);

        for (int i = 0; i < 11; i++) begin
            req = 4'b0001 << vecs[i].user;
            do_txn(vecs[i], 1'b0);
        end

        do_reset();
        chk("rst2_final", 32'(final_lock), 32'd0);
        chk("rst2_data", 32'(data_out), 32'd0);
        chk("rst2_owner", 32'(owner_id), 32'd2);

        // round robin with all requesters held
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            v = '{2'(i), 2'b11, 8'h00, 1'b0, 8'h00, 2'd2, 1'b0};
            do_txn(v, 1'b1);
        end
        req = 4'd0;

        // grant timeout for user 3, then user 0 is next
        do_reset();
        req = 4'b1000;
        wait_gnt(ok);
        chk("to_gnt", 32'(gnt), 32'b1000);
        for (int i = 1; i < 16; i++) begin
            @(posedge clk);
            #1;
            if (i == 15) req = 4'b1001;
            if (gnt != 4'b1000 || timeout) begin
                chk("to_early", 32'({gnt, timeout}), 32'h10);
                break;
            end
        end
        @(posedge clk);
        #1;
        bump_viol();
        chk("to_pulse", 32'(timeout), 32'd1);
        chk("to_gnt0", 32'(gnt), 32'd0);
        chk("to_viol", 32'(viol_cnt), 32'(exp_viol));
        @(posedge clk);
        #1;
        chk("to_next", 32'(gnt), 32'b0001);
        chk("to_len", 32'(timeout), 32'd0);
        req = 4'b1000;
        @(posedge clk);
        #1;
        chk("rel_gnt", 32'(gnt), 32'd0);
        chk("rel_quiet", 32'({ack, nack, timeout}), 32'd0);
        req = 4'd0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/user_lock_arbiter.md
Name: user_lock_arbiter

Overview:
- Shares one 8-bit user-locked configuration register between four requesters.
- Arbitrates access round-robin and sequences each write or ownership-transfer transaction.
- Enforces that only the current owner can modify the register. Identity comes from the grant index, never from requester-supplied data.
- Sits between the per-user bus masters and the protected register; it replaces direct `usr_id`-gated writes.

Parameters:
- RESET_OWNER, 2, owner ID loaded at reset (0-3).
- GNT_TIMEOUT, 16, maximum cycles a grant is held without `wr_valid` before forced release (2-255).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  level request, one bit per user ID; bit i = user i.
- gnt  output  4  one-hot grant; all zero when idle.
- wr_valid  input  1  granted requester presents an operation this cycle.
- wr_op  input  2  operation: 00 write data, 01 transfer ownership, 10 lock-final, 11 reserved.
- wr_data  input  8  write payload; for op 01, bits [1:0] hold the new owner ID.
- ack  output  1  one-cycle pulse: operation accepted.
- nack  output  1  one-cycle pulse: operation rejected.
- timeout  output  1  one-cycle pulse: grant revoked by timer.
- data_out  output  8  protected register value.
- owner_id  output  2  current owner.
- final_lock  output  1  sticky; register frozen until reset.
- viol_cnt  output  8  violation counter (see Optional Feature).

Behaviour:
- Reset values (asynchronous, immediate):
  - `gnt`=0, `ack`=`nack`=`timeout`=0
  - `data_out`=0, `owner_id`=RESET_OWNER, `final_lock`=0
  - round-robin pointer=0, timer=0, `viol_cnt`=0, state=IDLE
- Reset mid-transaction aborts it; no response pulse is issued.
- States: IDLE, GRANT, RESP.
- IDLE:
  - If any `req` bit is set, select the first set bit at or after the pointer, wrapping 3->0.
  - Next cycle: `gnt`=onehot(sel), state=GRANT, timer=0, pointer=(sel+1) mod 4.
  - If `req`=0, stay in IDLE; pointer unchanged.
- GRANT:
  - Granted index g is the authenticated user ID.
  - `wr_valid`=1: evaluate the operation, register the result, go to RESP. `gnt` drops on entry to RESP.
  - `wr_valid`=0 and `req[g]`=0: release to IDLE, no pulse.
  - `wr_valid`=0 and timer=GNT_TIMEOUT-1: pulse `timeout`, go to IDLE.
  - Otherwise increment the timer.
  - `wr_valid` takes priority over req-drop and timeout in the same cycle.
- Operation evaluation (all accepted updates land on the RESP-entry edge):
  - op 00: accept if g==`owner_id` and !`final_lock`; `data_out`<=`wr_data`.
  - op 01: accept if g==`owner_id` and !`final_lock`; `owner_id`<=`wr_data[1:0]`. Transfer to self is accepted with no change.
  - op 10: accept if g==`owner_id`; `final_lock`<=1. Repeating it while already locked is accepted.
  - op 11: always rejected.
  - Any rejection leaves all state unchanged and counts as a violation.
- RESP:
  - Exactly one of `ack`/`nack` is high for this single cycle; `gnt`=0.
  - Next state is IDLE. New requests are sampled in IDLE, so back-to-back transactions are 3 cycles apart minimum.
- Latency: `req` rise to `gnt` = 1 cycle; `wr_valid` to `ack`/`nack` = 1 cycle.
- `ack`, `nack` and `timeout` are mutually exclusive; at most one is high in any cycle.
- `wr_valid` outside GRANT is ignored.

Optional Feature:
- Macro: USR_LOCK_AUDIT_EN.
- Defined: `viol_cnt` increments on every `nack` and on every `timeout`, saturating at 255. It is cleared only by reset.
- Undefined: no counter logic is built; `viol_cnt` is driven constant 0.

Test Plan:
- Reset, then idle 5 cycles -> `data_out`=0x00, `owner_id`=2, `gnt`=0, `final_lock`=0.
- `req`=0100, op 00, data 0xA5 -> `gnt`=0100 after 1 cycle; `ack` pulse; `data_out`=0xA5.
- `req`=0010, op 00, data 0x3C -> `nack`; `data_out` stays 0xA5; with USR_LOCK_AUDIT_EN, `viol_cnt`=1.
- User 2 issues op 01 with data 0x01, then user 1 writes 0x77 -> both ack; `owner_id`=1; `data_out`=0x77; a following user-2 write gets `nack`.
- `req`=1111 held continuously, pointer=0, each grantee sends op 11 -> grant order 0,1,2,3,0 with `nack` each time.
- User 3 granted and holds `req` with no `wr_valid` for 16 cycles (GNT_TIMEOUT=16) -> `timeout` pulse; `gnt`=0; next grant goes to user 0 if it is requesting.
- Owner issues op 10, then op 00 with data 0xFF -> `ack` then `nack`; `final_lock`=1; `data_out` unchanged. Assert reset -> `final_lock`=0, `data_out`=0.
